// File: rtl/color_select_ctrl_pkg.sv
// Shared game definitions: colour width, colour-count limit and controller state encoding.
package color_select_ctrl_pkg;

    localparam int unsigned COLOR_W    = 3;
    localparam int unsigned MAX_COLORS = 8;

    typedef logic [COLOR_W-1:0] color_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEL_REQ  = 3'd1,
        ST_SEL_WAIT = 3'd2,
        ST_NEW_REQ  = 3'd3,
        ST_NEW_WAIT = 3'd4
    } state_t;

    // Clamp the requested colour count to the playable range 2..MAX_COLORS.
    function automatic logic [3:0] effective_colors(input logic [3:0] color_num);
        if (color_num < 4'd2)
            return 4'd2;
        else if (color_num > 4'(MAX_COLORS))
            return 4'(MAX_COLORS);
        else
            return color_num;
    endfunction

endpackage

// File: rtl/color_select_ctrl_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and one-cycle press pulse.
module button_debounce
    import color_select_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic BTN,
    output logic PRESS
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             btn_s;
    logic             accept;

    assign btn_s  = sync_q[1];
    // The new level is taken once it has differed from the accepted level for DEBOUNCE_CYCLES cycles.
    assign accept = (btn_s != level_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            PRESS   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], BTN};
            PRESS  <= accept && btn_s;
            if (btn_s == level_q) begin
                cnt_q <= '0;
            end else if (accept) begin
                level_q <= btn_s;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/color_select_ctrl.sv
// Colour-select controller: cursor navigation, colour-change and new-game handshakes, move counting.
module color_select_ctrl
    import color_select_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    input  logic         BTN_LEFT,
    input  logic         BTN_RIGHT,
    input  logic         BTN_SELECT,
    input  logic         BTN_NEW,
    input  logic [3:0]   COLOR_NUM,
    input  logic [2:0]   CURRENT_COLOR,
    input  logic         CHANGING_COLOR,
    input  logic         STARTED_GAME,
    input  logic         INITIAL_INIT,
    output logic [2:0]   COLOR_SELECTED,
    output logic         COLOR_SEL_SIG,
    output logic         START_NEW_GAME,
    output logic [2:0]   CURSOR,
    output logic [7:0]   MOVE_COUNT,
    output logic         BUSY
);

    state_t     state_q, state_d;
    logic       left_p, right_p, sel_p, new_p;
    logic [1:0] started_sync_q;
    logic       started;
    color_t     cursor_q, selected_q;
    logic [7:0] moves_q;
    logic [3:0] n_colors;
    color_t     n_last;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left   (.CLOCK(CLOCK), .RESET_N(RESET_N), .BTN(BTN_LEFT),   .PRESS(left_p));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right  (.CLOCK(CLOCK), .RESET_N(RESET_N), .BTN(BTN_RIGHT),  .PRESS(right_p));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (.CLOCK(CLOCK), .RESET_N(RESET_N), .BTN(BTN_SELECT), .PRESS(sel_p));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_new    (.CLOCK(CLOCK), .RESET_N(RESET_N), .BTN(BTN_NEW),    .PRESS(new_p));

    assign started  = started_sync_q[1];
    assign n_colors = effective_colors(COLOR_NUM);
    assign n_last   = 3'(n_colors - 4'd1);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= ST_IDLE;
            started_sync_q <= '0;
        end else begin
            state_q        <= state_d;
            started_sync_q <= {started_sync_q[0], STARTED_GAME};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (new_p)
                    state_d = ST_NEW_REQ;
                else if (sel_p && INITIAL_INIT && (cursor_q != CURRENT_COLOR))
                    state_d = ST_SEL_REQ;
            end
            ST_SEL_REQ:  if (CHANGING_COLOR)  state_d = ST_SEL_WAIT;
            ST_SEL_WAIT: if (!CHANGING_COLOR) state_d = ST_IDLE;
            ST_NEW_REQ:  if (started)         state_d = ST_NEW_WAIT;
            ST_NEW_WAIT: if (!started)        state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        COLOR_SEL_SIG  = (state_q == ST_SEL_REQ);
        START_NEW_GAME = (state_q == ST_NEW_REQ);
        BUSY           = (state_q != ST_IDLE);
        COLOR_SELECTED = selected_q;
        CURSOR         = cursor_q;
        MOVE_COUNT     = moves_q;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cursor_q   <= '0;
            moves_q    <= '0;
            selected_q <= '0;
        end else begin
            if (state_q == ST_NEW_REQ && state_d == ST_NEW_WAIT) begin
                cursor_q <= '0;
                moves_q  <= '0;
            end else begin
                // An out-of-range cursor after a colour-count change wins over navigation.
                if ({1'b0, cursor_q} >= n_colors)
                    cursor_q <= '0;
                else if (state_q == ST_IDLE && right_p && !left_p)
                    cursor_q <= (cursor_q == n_last) ? '0 : cursor_q + 3'd1;
                else if (state_q == ST_IDLE && left_p && !right_p)
                    cursor_q <= (cursor_q == '0) ? n_last : cursor_q - 3'd1;
                if (state_q == ST_SEL_WAIT && state_d == ST_IDLE && moves_q != '1)
                    moves_q <= moves_q + 8'd1;
            end
            if (state_q == ST_IDLE && state_d == ST_SEL_REQ)
                selected_q <= cursor_q;
        end
    end

endmodule

// File: tb/tb_color_select_ctrl.sv
// Scoreboard bench for color_select_ctrl: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_color_select_ctrl;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       b_left = 1'b0, b_right = 1'b0, b_select = 1'b0, b_new = 1'b0;
    logic [3:0] color_num = 4'd6;
    logic [2:0] current_color = 3'd0;
    logic       changing = 1'b0, started = 1'b0, init = 1'b0;
    logic [2:0] color_selected, cursor;
    logic       color_sel_sig, start_new_game, busy;
    logic [7:0] move_count;

    always #5 clk = ~clk;

    color_select_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .CLOCK(clk), .RESET_N(rst_n),
        .BTN_LEFT(b_left), .BTN_RIGHT(b_right), .BTN_SELECT(b_select), .BTN_NEW(b_new),
        .COLOR_NUM(color_num), .CURRENT_COLOR(current_color),
        .CHANGING_COLOR(changing), .STARTED_GAME(started), .INITIAL_INIT(init),
        .COLOR_SELECTED(color_selected), .COLOR_SEL_SIG(color_sel_sig),
        .START_NEW_GAME(start_new_game), .CURSOR(cursor), .MOVE_COUNT(move_count), .BUSY(busy)
    );

    typedef enum int {EV_CUR = 0, EV_SEL = 1, EV_NEW = 2, EV_IDLE = 3} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       value;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  m_cursor = 0;
    int  m_moves = 0;

    function automatic int eff_n(input int cn);
        if (cn < 2) return 2;
        if (cn > 8) return 8;
        return cn;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input ev_kind_t kind, input int value);
        ev_t e;
        e.kind = kind;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t kind, input int value);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d value %0d expected none", int'(kind), value);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(kind), int'(e.kind));
            check("event_value", value, e.value);
        end
    endtask

    // Monitor: every visible output change is an event that must match the head of the queue.
    logic [2:0] p_cursor = '0;
    logic       p_sel = 1'b0, p_new = 1'b0, p_busy = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (cursor != p_cursor)          observe(EV_CUR, int'(cursor));
            if (color_sel_sig && !p_sel)     observe(EV_SEL, int'(color_selected));
            if (start_new_game && !p_new)    observe(EV_NEW, 0);
            if (!busy && p_busy)             observe(EV_IDLE, int'(move_count) * 8 + int'(cursor));
        end
        p_cursor = cursor;
        p_sel    = color_sel_sig;
        p_new    = start_new_game;
        p_busy   = busy;
    end

    function automatic logic out_sel(input int which);
        case (which)
            0:       return color_sel_sig;
            1:       return start_new_game;
            default: return busy;
        endcase
    endfunction

    task automatic wait_out(input int which, input logic val, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (out_sel(which) != val && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(out_sel(which)), int'(val));
    endtask

    // mask = {new, select, right, left}; held long enough to debounce, then released the same way.
    task automatic press(input logic [3:0] mask);
        @(posedge clk); #1;
        {b_new, b_select, b_right, b_left} = mask;
        repeat (DB + 8) @(posedge clk);
        #1;
        {b_new, b_select, b_right, b_left} = 4'b0000;
        repeat (DB + 8) @(posedge clk);
        #1;
    endtask

    task automatic do_move(input int dir);
        int n;
        n = eff_n(int'(color_num));
        m_cursor = (dir == 0) ? (m_cursor + 1) % n : (m_cursor + n - 1) % n;
        push(EV_CUR, m_cursor);
        press((dir == 0) ? 4'b0010 : 4'b0001);
    endtask

    task automatic do_select(input logic hold_right);
        logic accept;
        accept = init && (m_cursor != int'(current_color));
        if (accept) begin
            push(EV_SEL, m_cursor);
            m_moves = (m_moves < 255) ? m_moves + 1 : 255;
            push(EV_IDLE, m_moves * 8 + m_cursor);
        end
        press(4'b0100);
        if (accept) begin
            wait_out(0, 1'b1, "sel_sig_rise");
            check("color_selected", int'(color_selected), m_cursor);
            repeat (3) @(posedge clk);
            #1 changing = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("sel_sig_drop", int'(color_sel_sig), 0);
            check("sel_wait_busy", int'(busy), 1);
            if (hold_right) press(4'b0010);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 changing = 1'b0;
            wait_out(2, 1'b0, "sel_done");
            check("move_count", int'(move_count), m_moves);
        end else begin
            repeat (3) @(negedge clk);
            check("sel_dropped_busy", int'(busy), 0);
            check("sel_dropped_sig", int'(color_sel_sig), 0);
            check("sel_dropped_moves", int'(move_count), m_moves);
        end
    endtask

    task automatic do_new(input logic with_select);
        push(EV_NEW, 0);
        if (m_cursor != 0) push(EV_CUR, 0);
        push(EV_IDLE, 0);
        m_cursor = 0;
        m_moves = 0;
        press(with_select ? 4'b1100 : 4'b1000);
        wait_out(1, 1'b1, "new_req");
        check("new_no_sel", int'(color_sel_sig), 0);
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 started = 1'b1;
        wait_out(1, 1'b0, "new_ack");
        check("new_wait_cursor", int'(cursor), 0);
        check("new_wait_moves", int'(move_count), 0);
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 started = 1'b0;
        wait_out(2, 1'b0, "new_done");
    endtask

    task automatic set_colors(input logic [3:0] cn);
        @(posedge clk); #1;
        color_num = cn;
        if (m_cursor >= eff_n(int'(cn))) begin
            m_cursor = 0;
            push(EV_CUR, 0);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_color_selected", int'(color_selected), 0);
        check("rst_sel_sig", int'(color_sel_sig), 0);
        check("rst_start_new", int'(start_new_game), 0);
        check("rst_cursor", int'(cursor), 0);
        check("rst_move_count", int'(move_count), 0);
        check("rst_busy", int'(busy), 0);
        #11 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 init = 1'b1;

        // Wrap-around at N=6.
        do_move(1);
        check("wrap_left", int'(cursor), 5);
        do_move(0);
        check("wrap_right", int'(cursor), 0);
        do_move(1);
        check("wrap_left2", int'(cursor), 5);

        // Accepted colour change from cursor 3 while the board colour is 1.
        do_move(1);
        do_move(1);
        current_color = 3'd1;
        do_select(1'b0);

        // Selecting the current colour, and selecting before the first board, are both dropped.
        do_move(1);
        current_color = 3'd2;
        do_select(1'b0);
        init = 1'b0;
        current_color = 3'd0;
        do_select(1'b0);
        init = 1'b1;

        // Presses while the responder is busy are discarded.
        do_select(1'b1);

        // Short bounce on SELECT must not produce a press.
        @(posedge clk); #1 b_select = 1'b1;
        repeat (2) @(posedge clk);
        #1 b_select = 1'b0;
        repeat (DB + 8) @(negedge clk);
        check("glitch_busy", int'(busy), 0);
        check("glitch_queue", exp_q.size(), 0);

        // Colour-count clamping and cursor forcing.
        do_move(0);
        do_move(0);
        do_move(0);
        set_colors(4'd4);
        set_colors(4'd0);
        set_colors(4'd15);
        do_move(1);
        set_colors(4'd9);
        check("clamp_high", int'(cursor), 7);
        set_colors(4'd1);

        // NEW wins over a simultaneous SELECT.
        do_move(0);
        current_color = 3'd0;
        do_new(1'b1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: do_move(int'($urandom_range(0, 1)));
                3, 4, 5: begin
                    current_color = 3'($urandom_range(0, 7));
                    init = ($urandom_range(0, 5) != 0);
                    do_select(1'($urandom_range(0, 1)));
                    init = 1'b1;
                end
                6: set_colors(4'($urandom_range(0, 15)));
                default: do_new(1'($urandom_range(0, 1)));
            endcase
        end

        // Saturation of the move counter.
        set_colors(4'd8);
        while (m_moves < 255) begin
            current_color = 3'(m_cursor ^ 1);
            do_select(1'b0);
        end
        current_color = 3'(m_cursor ^ 1);
        do_select(1'b0);
        check("moves_saturated", int'(move_count), 255);

        // Asynchronous reset in the middle of a colour request.
        push(EV_SEL, m_cursor);
        press(4'b0100);
        wait_out(0, 1'b1, "pre_reset_sel");
        #2 rst_n = 1'b0;
        #1;
        check("async_sel_sig", int'(color_sel_sig), 0);
        check("async_moves", int'(move_count), 0);
        check("async_busy", int'(busy), 0);
        check("async_cursor", int'(cursor), 0);
        m_cursor = 0;
        m_moves = 0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_idle", int'(busy), 0);
        do_move(0);
        check("post_reset_move", int'(cursor), 1);

        repeat (10) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
